// File: rtl/pwm_cmd_pkg.sv
// Shared constants for the PWM command front-end: frame bytes, response codes,
// duty limits and the frame-parser state encoding.
package pwm_cmd_pkg;

  localparam logic [7:0] HDR      = 8'hA5;
  localparam logic [7:0] CSUM_KEY = 8'h5A;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned DUTY_W   = 7;
  localparam logic [7:0]  DUTY_MAX = 8'd100;
  localparam logic [7:0]  CH_MAX   = 8'd3;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GET_CH   = 2'd1;
  localparam logic [1:0] ST_GET_DUTY = 2'd2;
  localparam logic [1:0] ST_GET_CSUM = 2'd3;

  function automatic logic [7:0] frame_csum(input logic [7:0] ch, input logic [7:0] duty);
    return ch ^ duty ^ CSUM_KEY;
  endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Inter-byte gap counter: cleared by clr or while disabled, counts while enabled,
// and raises expire during the cycle the count reaches TIMEOUT_CYCLES.
module cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             expire_r;

  // gap counter; expire_r is asserted alongside cnt_r == CNT_MAX
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      expire_r <= 1'b0;
    end else if (clr || !en) begin
      cnt_r    <= '0;
      expire_r <= 1'b0;
    end else begin
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      expire_r <= (cnt_r == CNT_LAST);
    end
  end

  assign expire = expire_r;

endmodule

// File: rtl/pwm_duty_cmd.sv
// UART command front-end: parses A5/ch/duty/csum frames into four duty registers
// for the PWM stage and returns a single-entry ACK/NAK response per frame.
module pwm_duty_cmd
  import pwm_cmd_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 8_000_000,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [NUM_CH*DUTY_W-1:0] duty_flat,
  output logic                     update,
  output logic                     err_overrun
);

  localparam int unsigned TIMEOUT_CYCLES = CLOCK_FREQ / 1_000_000 * TIMEOUT_US;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] ch_r;
  logic [7:0] duty_byte_r;
  duty_t      duty_r [NUM_CH];
  logic [7:0] tx_data_r;
  logic       tx_valid_r;
  logic       update_r;
  logic       err_overrun_r;
  logic       expire_s;
  logic       frame_done_s;
  logic       frame_good_s;
  logic [7:0] resp_s;

  cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (rx_valid),
    .en    (state_r != ST_IDLE),
    .expire(expire_s)
  );

  assign frame_done_s = rx_valid && (state_r == ST_GET_CSUM);
  assign frame_good_s = (ch_r <= CH_MAX) && (duty_byte_r <= DUTY_MAX) &&
                        (rx_data == frame_csum(ch_r, duty_byte_r));
  assign resp_s       = frame_good_s ? ACK : NAK;

  // next-state: a received byte always wins over a simultaneous timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && (rx_data == HDR)) begin
          state_nxt_s = ST_GET_CH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GET_CH: begin
        if (rx_valid) begin
          state_nxt_s = ST_GET_DUTY;
        end else if (expire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GET_CH;
        end
      end
      ST_GET_DUTY: begin
        if (rx_valid) begin
          state_nxt_s = ST_GET_CSUM;
        end else if (expire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GET_DUTY;
        end
      end
      ST_GET_CSUM: begin
        if (rx_valid || expire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GET_CSUM;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // parser state and latched frame fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ch_r        <= 8'h00;
      duty_byte_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      if (rx_valid && (state_r == ST_GET_CH)) begin
        ch_r <= rx_data;
      end
      if (rx_valid && (state_r == ST_GET_DUTY)) begin
        duty_byte_r <= rx_data;
      end
    end
  end

  // duty registers and the update strobe that accompanies every accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_r[0] <= 7'd0;
      duty_r[1] <= 7'd25;
      duty_r[2] <= 7'd50;
      duty_r[3] <= 7'd75;
      update_r  <= 1'b0;
    end else begin
      if (frame_done_s && frame_good_s) begin
        duty_r[ch_r[1:0]] <= duty_byte_r[DUTY_W-1:0];
      end
      update_r <= frame_done_s && frame_good_s;
    end
  end

  // single-entry response holder; a new response while one is stuck is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_r    <= 1'b0;
      tx_data_r     <= 8'h00;
      err_overrun_r <= 1'b0;
    end else if (frame_done_s) begin
      if (tx_valid_r && !tx_ready) begin
        err_overrun_r <= 1'b1;
      end else begin
        tx_valid_r <= 1'b1;
        tx_data_r  <= resp_s;
      end
    end else if (tx_valid_r && tx_ready) begin
      tx_valid_r <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign duty_flat[g*DUTY_W +: DUTY_W] = duty_r[g];
  end

  assign tx_data     = tx_data_r;
  assign tx_valid    = tx_valid_r;
  assign update      = update_r;
  assign err_overrun = err_overrun_r;

endmodule
